multiplexor_nin_1out_reg: RTL and testbench

Parametrised N-input, one-output registered multiplexer with valid/ready handshakes on every channel. It is the datapath selector for multi-source operand/result routing. It supports an explicit select mode and an arbitrated mode, and has a one-entry output register so that no combinational path runs from data in to data out. Latency is one cycle, and throughput is one word per cycle.

---
 rtl/multiplexor_nin_1out_reg_if.sv | 47 ++++
 rtl/multiplexor_nin_1out_reg.sv | 113 +++++++++++
 tb/tb_multiplexor_nin_1out_reg.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiplexor_nin_1out_reg_if.sv
// multiplexor_nin_1out_reg_if
// Bundles the input channels, the select controls and the registered output
// channel of multiplexor_nin_1out_reg.
//
// Handshake rule (every channel): a word moves on a rising clk edge exactly
// when valid and ready are both high at that edge. valid never waits on ready.
// ready may depend on valid.
//
// Signals:
//   in_data    N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   N        per-channel valid
//   in_ready   N        per-channel ready, at most one bit high
//   sel_mode   1        1 = explicit select by sel, 0 = arbitrated
//   sel        SEL_W    channel picked in select mode
//   out_data   WIDTH    registered output word
//   out_chan   SEL_W    channel that supplied out_data
//   out_valid  1        output register holds a word
//   out_ready  1        downstream accepts the word
//   last_grant SEL_W    debug view of the arbiter's last-granted channel
// Modports: master = source/sink side (test environment), slave = the mux.
interface multiplexor_nin_1out_reg_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               sel_mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_chan;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   last_grant;

  modport master (
    output in_data, in_valid, sel_mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid, last_grant
  );

  modport slave (
    input  in_data, in_valid, sel_mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid, last_grant
  );
endinterface

// File: rtl/multiplexor_nin_1out_reg.sv
// multiplexor_nin_1out_reg
// N-input, one-output registered multiplexer. A channel is picked either
// explicitly (sel_mode=1, by sel) or by arbitration among valid channels
// (sel_mode=0). The picked word lands in a one-entry output register, so
// there is no combinational path from in_data to out_data. Latency is one
// cycle. The register reloads in the same edge it drains, so throughput is one
// word per cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multiplexor_nin_1out_reg_if.slave (data, handshakes, select)
//
// Build option:
//   MUX_RR_ARB_EN  defined: arbitrated mode is round-robin, starting after
//                  last_grant. Undefined (default): arbitrated mode is fixed
//                  priority, and the lowest valid index wins.
module multiplexor_nin_1out_reg #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  multiplexor_nin_1out_reg_if.slave       bus
);
  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_chan_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] last_grant_q;

  logic [WIDTH-1:0] in_words [N];
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             load_en;
  logic             transfer;
  logic [N-1:0]     ready_vec;

  for (genvar i = 0; i < N; i++) begin : g_split
    assign in_words[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // The register may load when it is empty or is being drained this edge.
  assign load_en = !out_valid_q || bus.out_ready;

  // Grant selection. When a grant exists, the grant index is always < N.
  always_comb begin
    logic [SEL_W-1:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (bus.sel_mode) begin
      if (int'(bus.sel) < N) begin
        grant     = bus.sel;
        grant_vld = 1'b1;
      end
    end else begin
`ifdef MUX_RR_ARB_EN
      // Search starts one past the last grant and wraps from N-1 to 0.
      for (int k = 1; k <= N; k++) begin
        idx = SEL_W'((int'(last_grant_q) + k) % N);
        if (!grant_vld && bus.in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
`else
      for (int i = 0; i < N; i++) begin
        idx = SEL_W'(i);
        if (!grant_vld && bus.in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
`endif
    end
  end

  // Ready goes only to the granted channel. In select mode it does not wait
  // for that channel's valid. It stays low while reset is asserted.
  always_comb begin
    ready_vec = '0;
    if (grant_vld && load_en && rst_n) begin
      ready_vec[grant] = 1'b1;
    end
  end

  assign transfer = grant_vld && load_en && bus.in_valid[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      last_grant_q <= SEL_W'(N - 1);
    end else if (transfer) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= in_words[grant];
      out_chan_q   <= grant;
      last_grant_q <= grant;
    end else if (bus.out_ready) begin
      // Drained with nothing to replace it. Data and channel keep their values.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = ready_vec;
  assign bus.out_data   = out_data_q;
  assign bus.out_chan   = out_chan_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_multiplexor_nin_1out_reg.sv
// Testbench for multiplexor_nin_1out_reg (N=4, WIDTH=16), plus a small
// N=3 instance for the out-of-range select case.
module tb_multiplexor_nin_1out_reg;
  localparam int W = 16;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiplexor_nin_1out_reg_if #(.WIDTH(W), .N(N)) bus ();
  multiplexor_nin_1out_reg_if #(.WIDTH(W), .N(3)) bus3 ();

  multiplexor_nin_1out_reg #(.WIDTH(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multiplexor_nin_1out_reg #(.WIDTH(W), .N(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];   // {chan[1:0], data[15:0]}
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: register occupancy and last granted channel.
  bit m_full = 0;
  int m_last = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level grant rule.
  task automatic model_grant(input bit mode, input int s, input logic [N-1:0] v,
                             output bit gv, output int g);
    gv = 0;
    g  = 0;
    if (mode) begin
      if (s < N) begin gv = 1; g = s; end
    end else begin
`ifdef MUX_RR_ARB_EN
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!gv && v[c]) begin gv = 1; g = c; end
      end
`else
      for (int c = 0; c < N; c++) begin
        if (!gv && v[c]) begin gv = 1; g = c; end
      end
`endif
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, checks in_ready against the model, and
  // predicts the word (if any) that the following edge captures.
  task automatic drive(input bit mode, input int s, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input bit ordy);
    bit load_en, gv;
    int g;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #2;
    bus.sel_mode  = mode;
    bus.sel       = 2'(s);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    load_en = !m_full || ordy;
    model_grant(mode, s, v, gv, g);
    exp_rdy = (gv && load_en) ? (N'(1) << g) : '0;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (gv && load_en && v[g]) begin
      exp_q.push_back({2'(g), d[g*W +: W]});
      m_last = g;
      m_full = 1;
    end else if (ordy) begin
      m_full = 0;
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom_range(0, 16'hFFFF));
    return d;
  endfunction

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    bus.in_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last_grant", 32'(bus.last_grant), 32'(N - 1));
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_full = 0;
    m_last = N - 1;
  endtask

  // ---------------- monitor ----------------
  // A word is consumed on the edge after this sample when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_word: got %0h with no word expected at %0t",
                 {bus.out_chan, bus.out_data}, $time);
      end else begin
        check("out_word", 32'({bus.out_chan, bus.out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N*W-1:0] d;
    bus.sel_mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus3.sel_mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      bus.sel_mode  = 1'($urandom_range(0, 1));
      bus.sel       = 2'($urandom_range(0, 3));
      bus.in_valid  = 4'($urandom_range(1, 15));
      bus.in_data   = rand_data();
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out_data", 32'(bus.out_data), 32'h0000);
      check("reset_out_chan", 32'(bus.out_chan), 32'd0);
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("reset_last_grant", 32'(bus.last_grant), 32'(N - 1));
    @(posedge clk);
    #2;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;

    // In_ready rises after release (select mode, empty register).
    drive(1, 0, 4'b0000, '0, 1);

    // Select mode with backpressure.
    d = rand_data();
    d[2*W +: W] = 16'hBEEF;
    drive(1, 2, 4'b0100, d, 0);
    drive(1, 2, 4'b0100, d, 0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_out_data", 32'(bus.out_data), 32'hBEEF);
    check("bp_out_chan", 32'(bus.out_chan), 32'd2);
    drive(1, 2, 4'b0000, d, 0);
    check("bp_hold_data", 32'(bus.out_data), 32'hBEEF);
    drive(1, 2, 4'b0000, d, 1);
    drive(1, 2, 4'b0000, d, 1);
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Arbitrated mode, all channels valid, full rate.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 4'b1111, rand_data(), 1);
      if (i > 0) check("arb_full_rate", 32'(bus.out_valid), 32'd1);
    end
    // Channel 0 drops out.
    for (int i = 0; i < 4; i++) drive(0, 0, 4'b1110, rand_data(), 1);

    // Reset mid-stream, then arbitration restarts from channel 0.
    for (int i = 0; i < 3; i++) drive(0, 0, 4'b1111, rand_data(), 1);
    pulse_reset();
    for (int i = 0; i < 5; i++) drive(0, 0, 4'b1111, rand_data(), 1);

    // Randomized traffic with mode switches and backpressure.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), 4'($urandom_range(0, 15)),
            rand_data(), $urandom_range(0, 3) != 0);
    end

    // Drain.
    for (int i = 0; i < 3; i++) drive(0, 0, 4'b0000, '0, 1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-range select on the N=3 instance.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      bus3.sel_mode = 1'b1;
      bus3.sel      = 2'd3;
      bus3.in_valid = 3'b111;
      bus3.in_data  = {16'h3333, 16'h2222, 16'h1111};
      bus3.out_ready = 1'b1;
      #1;
      check("sel_oob_in_ready", 32'(bus3.in_ready), 32'd0);
      check("sel_oob_out_valid", 32'(bus3.out_valid), 32'd0);
    end
    @(posedge clk);
    #2;
    bus3.sel = 2'd2;
    #1;
    check("sel2_n3_in_ready", 32'(bus3.in_ready), 32'b100);
    @(posedge clk);
    #2;
    bus3.in_valid = '0;
    check("sel2_n3_out_data", 32'(bus3.out_data), 32'h3333);
    check("sel2_n3_out_chan", 32'(bus3.out_chan), 32'd2);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
